pq_req_buffer: RTL

- Upstream front-end for the priority-queue devices on pq_if (heap and other implementations).
- Accepts ENQ/DEQ commands from a valid/ready producer and buffers them in a small FIFO.
- Issues one command at a time to the PQ, only when the PQ is not busy.
- Returns one response per command on a valid/ready port: dequeued key-value or an error flag. Decouples multi-cycle PQ latency from the producer.

---
 rtl/pq_pkg.sv | 40 ++++
 rtl/pq_req_fifo.sv | 57 +++++
 rtl/pq_req_buffer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pq_pkg.sv
// rtl/pq_pkg.sv - shared key-value, command and state types for the priority-queue devices and their front-end
package pq_pkg;

    localparam int KEY_WIDTH = 8;
    localparam int VAL_WIDTH = 8;

    // Empty-slot sentinel: largest key, zero value.
    localparam logic [KEY_WIDTH-1:0] KEY0 = '1;
    localparam logic [VAL_WIDTH-1:0] VAL0 = '0;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

    localparam kv_t KV0 = '{key: KEY0, val: VAL0};

    typedef enum logic [0:0] {
        PQ_OP_ENQ = 1'b0,
        PQ_OP_DEQ = 1'b1
    } pq_op_t;

    typedef struct packed {
        pq_op_t op;
        kv_t    kv;
    } pq_req_t;

    localparam int PQ_REQ_DEPTH = 4;

    typedef enum logic [1:0] {
        REQ_IDLE = 2'd0,
        REQ_WAIT = 2'd1,
        REQ_RSP  = 2'd2
    } req_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pq_req_fifo.sv
// rtl/pq_req_fifo.sv - synchronous command FIFO of pq_req_t entries
//   clk, rst (async, active-low) ; push + din write an entry (ignored when full)
//   pop drops the head (ignored when empty) ; full, empty, head describe the contents
module pq_req_fifo
    import pq_pkg::*;
#(
    parameter int DEPTH = PQ_REQ_DEPTH
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  pq_req_t din,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output pq_req_t head
);

    localparam int PTR_W = $clog2(DEPTH);

    pq_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/pq_req_buffer.sv
// rtl/pq_req_buffer.sv - command buffer and one-at-a-time issuer in front of a priority queue
//   req_*  : producer ENQ/DEQ commands (valid/ready), buffered in pq_req_fifo
//   rsp_*  : one response per command, in order (valid/ready): op, dequeued kv, error flag
//   pq_*   : issue strobes and kv to the PQ, head/status back from it
//   clk, rst (async, active-low)
//   Optional build macro PQ_REQ_STATS_EN adds stat_enq/stat_deq/stat_err (16-bit, saturating).
module pq_req_buffer
    import pq_pkg::*;
#(
    parameter int DEPTH = PQ_REQ_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  pq_op_t      req_op,
    input  kv_t         req_kv,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output pq_op_t      rsp_op,
    output kv_t         rsp_kv,
    output logic        rsp_err,
    output logic        pq_enq,
    output logic        pq_deq,
    output kv_t         pq_kvi,
    input  kv_t         pq_kvo,
    input  logic        pq_full,
    input  logic        pq_empty,
    input  logic        pq_busy
`ifdef PQ_REQ_STATS_EN
    ,
    output logic [15:0] stat_enq,
    output logic [15:0] stat_deq,
    output logic [15:0] stat_err
`endif
);

    req_state_t state;
    req_state_t state_nxt;

    logic    fifo_full;
    logic    fifo_empty;
    pq_req_t head;
    pq_req_t push_req;
    logic    push;

    logic launch;
    logic issue_enq;
    logic issue_deq;
    logic issue_err;

    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;
    assign push_req  = '{op: req_op, kv: req_kv};

    pq_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_req),
        .pop   (launch),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // A head command leaves the FIFO whenever IDLE sees the PQ free; it
    // either issues or is answered with an error without touching the PQ.
    always_comb begin
        launch    = (state == REQ_IDLE) && !fifo_empty && !pq_busy;
        issue_enq = launch && (head.op == PQ_OP_ENQ) && !pq_full;
        issue_deq = launch && (head.op == PQ_OP_DEQ) && !pq_empty;
        issue_err = launch && !issue_enq && !issue_deq;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= REQ_IDLE;
        else      state <= state_nxt;
    end

    // WAIT always spends at least one cycle, so a busy raised by the PQ
    // one cycle after the strobe is still observed.
    always_comb begin
        state_nxt = state;
        case (state)
            REQ_IDLE: if (launch)    state_nxt = issue_err ? REQ_RSP : REQ_WAIT;
            REQ_WAIT: if (!pq_busy)  state_nxt = REQ_RSP;
            REQ_RSP:  if (rsp_ready) state_nxt = REQ_IDLE;
            default:                 state_nxt = REQ_IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = (state == REQ_RSP);
        pq_enq    = issue_enq;
        pq_deq    = issue_deq;
        pq_kvi    = issue_enq ? head.kv : KV0;
    end

    // Response fields are latched at launch and held until the next launch,
    // so they are stable throughout RSP. pq_kvo is only valid at issue time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_op  <= PQ_OP_ENQ;
            rsp_kv  <= KV0;
            rsp_err <= 1'b0;
        end else if (launch) begin
            rsp_op  <= head.op;
            rsp_kv  <= issue_deq ? pq_kvo : KV0;
            rsp_err <= issue_err;
        end
    end

`ifdef PQ_REQ_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_enq <= '0;
            stat_deq <= '0;
            stat_err <= '0;
        end else begin
            if (issue_enq) stat_enq <= sat_inc16(stat_enq);
            if (issue_deq) stat_deq <= sat_inc16(stat_deq);
            if (issue_err) stat_err <= sat_inc16(stat_err);
        end
    end
`endif

endmodule
